fp_mul_issue: RTL and testbench

Operand-issue and result-collection front end for the pipelined single-precision multiplier. It accepts operand pairs on a valid/ready stream and drives the multiplier's `start`/`op_a`/`op_b`. It captures the multiplier's `done`/`res` into a first-word-fall-through result FIFO and presents results on a valid/ready stream. Credit accounting guarantees that every issued operation has a FIFO slot reserved, so the multiplier, which has no stall input, can never lose a result.

---
 rtl/fp_mul_issue_if.sv | 28 ++
 rtl/fp_mul_issue.sv | 55 +++++
 tb/tb_fp_mul_issue.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_issue_if.sv
// fp_mul_issue_if: operand, multiplier and result streams of fp_mul_issue
interface fp_mul_issue_if #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [DATA_W-1:0]           in_a;
    logic [DATA_W-1:0]           in_b;
    logic                        mul_start;
    logic [DATA_W-1:0]           mul_op_a;
    logic [DATA_W-1:0]           mul_op_b;
    logic                        mul_done;
    logic [DATA_W-1:0]           mul_res;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_res;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        err;
    modport master (
        output in_valid, in_a, in_b, mul_done, mul_res, out_ready,
        input  in_ready, mul_start, mul_op_a, mul_op_b, out_valid, out_res, level, err
    );
    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_res, out_ready,
        output in_ready, mul_start, mul_op_a, mul_op_b, out_valid, out_res, level, err
    );
endinterface

// File: rtl/fp_mul_issue.sv
// fp_mul_issue: credit-checked operand issue and in-order result FIFO for the pipelined multiplier
module fp_mul_issue #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input logic           clk,
    input logic           rst,
    fp_mul_issue_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     inflight, count;
    logic              accept, push, pop;
    always_comb begin
        accept = bus.in_valid & bus.in_ready;
        push   = bus.mul_done & (inflight != '0);
        pop    = bus.out_valid & bus.out_ready;
    end
    // credits cover both in-flight ops and buffered results, so a push always finds a free slot
    assign bus.level     = inflight + count;
    assign bus.in_ready  = bus.level < LW'(FIFO_DEPTH);
    assign bus.out_valid = count != '0;
    assign bus.out_res   = bus.out_valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= bus.mul_res;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mul_start <= 1'b0;
            bus.mul_op_a  <= '0;
            bus.mul_op_b  <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            inflight      <= '0;
            count         <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.mul_start <= accept;
            if (accept) begin
                bus.mul_op_a <= bus.in_a;
                bus.mul_op_b <= bus.in_b;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            inflight <= inflight + LW'(accept) - LW'(push);
            count    <= count + LW'(push) - LW'(pop);
            bus.err  <= bus.err | (bus.mul_done & (inflight == '0));
        end
    end
endmodule

// File: tb/tb_fp_mul_issue.sv
// tb_fp_mul_issue: directed and random checks of fp_mul_issue with a 4-cycle multiplier model
module tb_fp_mul_issue;
    localparam int DW = 32;
    localparam int D  = 8;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] r;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sb_exp;

    always #5 clk = ~clk;

    fp_mul_issue_if #(.DATA_W(DW), .FIFO_DEPTH(D)) bus ();
    fp_mul_issue #(.DATA_W(DW), .FIFO_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            e = e + 10'd1;
            p = p >> 1;
        end
        return {a[31] ^ b[31], e[7:0], p[45:23]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'(110 + $urandom % 30), 23'($urandom)};
    endfunction

    // 4-stage multiplier model sharing rst; force_done injects a done with nothing in flight
    logic [3:0]    pv;
    logic [DW-1:0] pd [4];
    always @(posedge clk) begin
        if (rst) pv <= '0;
        else begin
            pv    <= {pv[2:0], bus.mul_start};
            pd[0] <= fmul(bus.mul_op_a, bus.mul_op_b);
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            pd[3] <= pd[2];
        end
    end
    assign bus.mul_done = pv[3] | force_done;
    assign bus.mul_res  = force_done ? 32'hDEAD_BEEF : pd[3];

    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(fmul(bus.in_a, bus.in_b));
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_stale got %h with no result expected", bus.out_res);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (bus.out_res !== sb_exp) begin
                        errors++;
                        $display("FAIL sb_order got %h want %h", bus.out_res, sb_exp);
                    end
                end
            end
            if (bus.level > D) begin
                checks++;
                errors++;
                $display("FAIL level_bound got %0d want <= %0d", bus.level, D);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic run_single(input vec_t v);
        chk("single_ready", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                chk("start_c1", bus.mul_start, 1);
                chk("op_a_c1", bus.mul_op_a, v.a);
                chk("op_b_c1", bus.mul_op_b, v.b);
                bus.in_valid = 1'b0;
            end
            if (k == 2) chk("start_c2", bus.mul_start, 0);
            if (k == 5) chk("valid_c5", bus.out_valid, 0);
            if (k == 6) begin
                chk("valid_c6", bus.out_valid, 1);
                chk("res_c6", bus.out_res, v.r);
            end
            if (k == 7) begin
                chk("valid_c7", bus.out_valid, 0);
                chk("level_c7", bus.level, 0);
            end
        end
    endtask

    task automatic drain();
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while ((bus.level != 0 || bus.out_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_done", bus.level, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int n_acc, bad, bad_rdy, p0, cyc;
        logic v;
        vecs[0] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000};
        vecs[1] = '{32'h4000_0000, 32'h4000_0000, 32'h4080_0000};
        vecs[2] = '{32'hBF80_0000, 32'h4040_0000, 32'hC040_0000};
        vecs[3] = '{32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000};
        vecs[4] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        vecs[5] = '{32'h4040_0000, 32'h4040_0000, 32'h4110_0000};
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_start", bus.mul_start, 0);
        chk("rst_op_a", bus.mul_op_a, 0);
        chk("rst_op_b", bus.mul_op_b, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_res", bus.out_res, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_single(vecs[i]);

        // back-pressure: 10 pairs offered, only 8 credits
        p0 = pops;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a = rnd_fp();
        bus.in_b = rnd_fp();
        n_acc = 0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.in_ready !== (bus.level < D)) bad++;
            v = bus.in_ready;
            tick();
            if (v) begin
                n_acc++;
                bus.in_a = rnd_fp();
                bus.in_b = rnd_fp();
            end
        end
        chk("bp_accepted", n_acc, 8);
        chk("bp_ready_low", bus.in_ready, 0);
        chk("bp_level", bus.level, 8);
        chk("bp_ready_track", bad, 0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60 && n_acc < 10; c++) begin
            v = bus.in_ready;
            tick();
            if (v) begin
                n_acc++;
                bus.in_a = rnd_fp();
                bus.in_b = rnd_fp();
            end
        end
        drain();
        chk("bp_pops", pops - p0, 10);
        chk("bp_err", bus.err, 0);

        // streaming: 32 back-to-back, one result per cycle after fill
        p0 = pops;
        bad = 0;
        bad_rdy = 0;
        for (int k = 0; k < 42; k++) begin
            if ((bus.out_valid === 1'b1) != (k >= 6 && k <= 37)) bad++;
            if (k < 32) begin
                if (bus.in_ready !== 1'b1) bad_rdy++;
                bus.in_valid = 1'b1;
                bus.in_a = rnd_fp();
                bus.in_b = rnd_fp();
            end else bus.in_valid = 1'b0;
            tick();
        end
        chk("stream_ready", bad_rdy, 0);
        chk("stream_valid_pattern", bad, 0);
        chk("stream_pops", pops - p0, 32);

        // random stalls
        p0 = pops;
        n_acc = 0;
        cyc = 0;
        while (n_acc < 1000 && cyc < 10000) begin
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            bus.in_a = rnd_fp();
            bus.in_b = rnd_fp();
            if (bus.in_valid && bus.in_ready) n_acc++;
            tick();
            cyc++;
        end
        chk("rand_accepted", n_acc, 1000);
        drain();
        chk("rand_pops", pops - p0, 1000);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_err", bus.err, 0);

        // spurious done
        bus.out_ready = 1'b0;
        chk("spur_pre_level", bus.level, 0);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        chk("spur_err", bus.err, 1);
        chk("spur_level", bus.level, 0);
        chk("spur_valid", bus.out_valid, 0);
        tick();
        tick();
        chk("spur_err_sticky", bus.err, 1);
        rst = 1'b1;
        tick();
        chk("spur_err_rst", bus.err, 0);
        rst = 1'b0;
        tick();

        // reset with 5 ops outstanding
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_a = rnd_fp();
            bus.in_b = rnd_fp();
            tick();
        end
        bus.in_valid = 1'b0;
        chk("mid_level_pre", bus.level, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_in_ready", bus.in_ready, 1);
        chk("mid_start", bus.mul_start, 0);
        chk("mid_op_a", bus.mul_op_a, 0);
        chk("mid_op_b", bus.mul_op_b, 0);
        chk("mid_out_valid", bus.out_valid, 0);
        chk("mid_out_res", bus.out_res, 0);
        chk("mid_level", bus.level, 0);
        chk("mid_err", bus.err, 0);
        bus.out_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid !== 1'b0) bad++;
            tick();
        end
        chk("mid_no_stale", bad, 0);
        run_single(vecs[5]);
        chk("mid_err_end", bus.err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
